spi_flash_xfer: RTL and testbench
=================================

# spi_flash_xfer

Parametrised SPI mode-0 transaction engine for the serial flash port. It generalises the fixed RDID-only master and runs any transaction of the form "send N bytes, then receive M bytes" under a single chip-select assertion. Examples are RDID (0x9F, then read 3 bytes), READ (command plus 24-bit address, then read data), and WREN (command only). It sits between system control logic and the M25P16 pins, and runs from the 50 MHz system clock.

## Interface
- `CLK_DIV`, default 1: system clocks per SPICLK half-period, minimum 1. Default gives SPICLK = clk/2.
- `MAX_TX_BYTES`, default 4: capacity of `tx_data`.
- `MAX_RX_BYTES`, default 4: capacity of `rx_data`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `tx_len`  in  $clog2(MAX_TX_BYTES+1)  bytes to send; saturated to MAX_TX_BYTES.
- `rx_len`  in  $clog2(MAX_RX_BYTES+1)  bytes to receive; saturated to MAX_RX_BYTES.
- `tx_data`  in  8*MAX_TX_BYTES  send bytes; byte 0 in the top 8 bits; captured on `start`.
- `rx_data`  out  8*MAX_RX_BYTES  received bytes, right-aligned; last byte in [7:0].
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse at completion.
- `SPICLK`  out  1  serial clock; idles low.
- `SPIMOSI`  out  1  serial data out, MSB first.
- `SPIMISO`  in  1  serial data in.
- `chip_select`  out  1  active-low flash select.

## Operation
- **States:** IDLE, SHIFT, CS_HOLD, FINISH.
- **IDLE → SHIFT:** on `start` with N = 8*(tx_len+rx_len) > 0.
  - Capture `tx_data` and both lengths.
  - Clear `rx_data` to 0.
- **Zero-length request:** `start` with N = 0 goes IDLE → FINISH. `chip_select` is never asserted and `done` pulses.
- **SHIFT:** N bits are transferred.
  - Bit n, for n < 8*tx_len, is taken from the tx shift register, MSB first.
  - Remaining bits drive MOSI = 0.
  - MISO is shifted into the LSB of `rx_data` only for bits n ≥ 8*tx_len.
- **SPICLK rising edge:** the clk edge that sets SPICLK to 1 also captures SPIMISO, i.e. the value present just before the rise.
- **SPICLK falling edge:** the clk edge that clears SPICLK also updates SPIMOSI to the next bit.
- **SHIFT → CS_HOLD:** after the falling edge of bit N-1.
- **CS_HOLD → FINISH:** after CLK_DIV cycles.
- **FINISH:** on entry, deassert `chip_select`, pulse `done`, drop `busy`; next cycle return to IDLE.
- **start while busy:** ignored, not queued. `tx_data`/length changes during a transaction have no effect.
- **Reset values:** SPICLK = 0, SPIMOSI = 0, chip_select = 1, busy = 0, done = 0, rx_data = 0, state IDLE.
- **Reset mid-transaction:** asynchronously forces the reset values. No partial `done`.
- **rx_data:** holds its value until the next accepted non-zero `start`.

## Timing
- Edge 0 is the edge that samples `start`. Bit index n runs 0..N-1; D = CLK_DIV.
- **Edge 1:**
  - chip_select = 0 and busy = 1.
  - SPIMOSI = bit 0, or 0 if tx_len = 0.
- **SPICLK rises:** at edge 1 + D*(2n+1).
- **SPICLK falls:** at edge 1 + D*(2n+2).
- **Edge 1 + D*(2N+1):**
  - chip_select = 1, done = 1, busy = 0.
  - rx_data final.
- **Next accepted start:** edge 2 + D*(2N+1) at the earliest.
- **Counters:**
  - Bit counter width $clog2(8*(MAX_TX_BYTES+MAX_RX_BYTES)+1).
  - Divider width $clog2(D)+1, wrapping at D-1.
- **Reference case, D = 1, RDID:** 1 tx byte + 3 rx bytes = 32 SPICLK rising edges.
  - CS is low for 65 clk cycles (1.3 µs).
  - done at edge 66.

## Test plan
- **RDID vs M25P16 model:** reset_n low 100 ns, then start with tx_data top byte 0x9F, tx_len = 1, rx_len = 3 → MOSI bits 1,0,0,1,1,1,1,1 on rising edges 1-8; 32 rising edges; rx_data[23:0] = 0x202015; done at edge 66.
- **CLK_DIV = 3, READ:** tx = 03 00 00 00, rx_len = 2 → SPICLK period 6 clk; 48 rising edges; MOSI all zero after the first byte; done at edge 1 + 3*97 = 292.
- **WREN-style command only:** tx = 0x06, rx_len = 0 → 8 rising edges; rx_data = 0; done at edge 18.
- **Zero length:** tx_len = rx_len = 0 → chip_select stays 1; no SPICLK edges; done pulses exactly once.
- **start while busy, plus re-run:** pulse start mid-RDID → ignored, still 32 edges. A second RDID after done → identical 0x202015.
- **Reset mid-transaction:** reset_n low after 10 SPICLK rising edges → chip_select = 1, SPICLK = 0, busy = 0, no done pulse. A following RDID passes.

Source files
------------

// File: rtl/spi_flash_xfer.sv
// SPI mode-0 flash transaction engine: sends tx_len bytes, then receives rx_len bytes,
// all under one chip-select assertion.
module spi_flash_xfer #(
    parameter int CLK_DIV      = 1,
    parameter int MAX_TX_BYTES = 4,
    parameter int MAX_RX_BYTES = 4,
    localparam int TXL_W = $clog2(MAX_TX_BYTES + 1),
    localparam int RXL_W = $clog2(MAX_RX_BYTES + 1),
    localparam int TX_W  = 8 * MAX_TX_BYTES,
    localparam int RX_W  = 8 * MAX_RX_BYTES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [TXL_W-1:0] tx_len,
    input  logic [RXL_W-1:0] rx_len,
    input  logic [TX_W-1:0]  tx_data,
    output logic [RX_W-1:0]  rx_data,
    output logic             busy,
    output logic             done,
    output logic             SPICLK,
    output logic             SPIMOSI,
    input  logic             SPIMISO,
    output logic             chip_select
);

    localparam int BC_W  = $clog2(8 * (MAX_TX_BYTES + MAX_RX_BYTES) + 1);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, FINISH} state_t;

    state_t            state_q, state_d;
    logic              launch_q;
    logic [DIV_W-1:0]  div_q;
    logic [BC_W-1:0]   bit_cnt_q, tx_bits_q, n_bits_q;
    logic [TX_W-1:0]   tx_sr_q;
    logic [RX_W-1:0]   rx_q;
    logic              sclk_q, mosi_q, cs_q, busy_q, done_q;
    logic              sclk_d, mosi_d, cs_d, busy_d, done_d;

    logic [BC_W-1:0]   tx_bits_in, n_bits_in;
    logic              accept, start_shift, tick, shifting, counting;
    logic              sclk_rise, sclk_fall, last_bit;

    function automatic logic [BC_W-1:0] byte_bits(input int len, input int max_bytes);
        int sat;
        sat = (len > max_bytes) ? max_bytes : len;
        return BC_W'(8 * sat);
    endfunction

    assign tx_bits_in  = byte_bits(int'(tx_len), MAX_TX_BYTES);
    assign n_bits_in   = tx_bits_in + byte_bits(int'(rx_len), MAX_RX_BYTES);
    assign accept      = (state_q == IDLE) && start;
    assign start_shift = accept && (n_bits_in != '0);

    // The first SHIFT cycle only asserts chip select and presents bit 0; the divider runs after it.
    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign shifting  = (state_q == SHIFT) && !launch_q;
    assign counting  = shifting || (state_q == CS_HOLD);
    assign sclk_rise = shifting && tick && !sclk_q;
    assign sclk_fall = shifting && tick && sclk_q;
    assign last_bit  = (bit_cnt_q == n_bits_q - BC_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            launch_q  <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_bits_q <= '0;
            n_bits_q  <= '0;
            rx_q      <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            launch_q <= start_shift;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;

            if (counting)
                div_q <= tick ? '0 : div_q + DIV_W'(1);
            else
                div_q <= '0;

            if (start_shift) begin
                tx_bits_q <= tx_bits_in;
                n_bits_q  <= n_bits_in;
                bit_cnt_q <= '0;
                rx_q      <= '0;
            end

            if (sclk_rise && (bit_cnt_q >= tx_bits_q))
                rx_q <= {rx_q[RX_W-2:0], SPIMISO};

            if (sclk_fall)
                bit_cnt_q <= bit_cnt_q + BC_W'(1);
        end
    end

    // Payload shift register carries no reset; it is reloaded on every accepted start.
    always_ff @(posedge clk) begin
        if (accept)
            tx_sr_q <= tx_data;
        else if (sclk_fall)
            tx_sr_q <= tx_sr_q << 1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (n_bits_in == '0) ? FINISH : SHIFT;
            SHIFT:   if (sclk_fall && last_bit) state_d = CS_HOLD;
            CS_HOLD: if (tick) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sclk_d = sclk_q;
        mosi_d = mosi_q;
        cs_d   = cs_q;
        busy_d = busy_q;
        done_d = 1'b0;

        if ((state_q == SHIFT) && launch_q) begin
            cs_d   = 1'b0;
            busy_d = 1'b1;
            mosi_d = (tx_bits_q != '0) && tx_sr_q[TX_W-1];
        end

        if (sclk_rise)
            sclk_d = 1'b1;

        // Next bit is the one below the current MSB; receive-phase bits drive zero.
        if (sclk_fall) begin
            sclk_d = 1'b0;
            mosi_d = ((bit_cnt_q + BC_W'(1)) < tx_bits_q) && tx_sr_q[TX_W-2];
        end

        if ((state_d == FINISH) && (state_q != FINISH)) begin
            cs_d   = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
        end
    end

    assign rx_data     = rx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign SPICLK      = sclk_q;
    assign SPIMOSI     = mosi_q;
    assign chip_select = cs_q;

endmodule

// File: tb/tb_spi_flash_xfer.sv
// Bench for spi_flash_xfer: two instances (CLK_DIV 1 and 3) each talking to a small
// M25P16-like responder; a scoreboard checks each completed transaction and timed probes.
module tb_spi_flash_xfer;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset_n;
    logic        start_a, start_b;
    logic [2:0]  txl_a, rxl_a, txl_b, rxl_b;
    logic [31:0] txd_a, txd_b, rx_a, rx_b;
    logic        busy_a, done_a, sclk_a, mosi_a, cs_a;
    logic        busy_b, done_b, sclk_b, mosi_b, cs_b;
    logic        miso_a = 1'b0;
    logic        miso_b = 1'b0;

    spi_flash_xfer #(.CLK_DIV(1), .MAX_TX_BYTES(4), .MAX_RX_BYTES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .tx_len(txl_a), .rx_len(rxl_a),
        .tx_data(txd_a), .rx_data(rx_a), .busy(busy_a), .done(done_a), .SPICLK(sclk_a),
        .SPIMOSI(mosi_a), .SPIMISO(miso_a), .chip_select(cs_a));

    spi_flash_xfer #(.CLK_DIV(3), .MAX_TX_BYTES(4), .MAX_RX_BYTES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .tx_len(txl_b), .rx_len(rxl_b),
        .tx_data(txd_b), .rx_data(rx_b), .busy(busy_b), .done(done_b), .SPICLK(sclk_b),
        .SPIMOSI(mosi_b), .SPIMISO(miso_b), .chip_select(cs_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: RDID returns 20 20 15; READ returns 5A+addr, 5B+addr, ...
    function automatic logic flash_bit(input logic [7:0] cmd, input logic [23:0] addr, input int idx);
        logic [23:0] id;
        logic [7:0]  dbyte;
        int          k;
        id = 24'h202015;
        if (cmd == 8'h9F && idx >= 8 && idx < 32) begin
            id = id << (idx - 8);
            return id[23];
        end
        if (cmd == 8'h03 && idx >= 32) begin
            k = idx - 32;
            dbyte = 8'h5A + addr[7:0] + 8'(k / 8);
            dbyte = dbyte << (k % 8);
            return dbyte[7];
        end
        return 1'b0;
    endfunction

    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [23:0] addr_a = '0, addr_b = '0;
    logic [63:0] msr_a = '0, msr_b = '0;
    int          bitc_a = 0, bitc_b = 0, tot_rise_a = 0, tot_rise_b = 0;
    logic        sp_a = 1'b0, sp_b = 1'b0, cp_a = 1'b1, cp_b = 1'b1;

    always @(negedge clk) begin
        if (!cs_a && cp_a) begin bitc_a = 0; cmd_a = '0; addr_a = '0; msr_a = '0; end
        if (sclk_a && !sp_a) tot_rise_a++;
        if (!cs_a && sclk_a && !sp_a) begin
            if (bitc_a < 8) cmd_a = {cmd_a[6:0], mosi_a};
            else if (bitc_a < 32) addr_a = {addr_a[22:0], mosi_a};
            msr_a = {msr_a[62:0], mosi_a};
            bitc_a++;
        end else if (!cs_a && !sclk_a && sp_a) begin
            miso_a = flash_bit(cmd_a, addr_a, bitc_a);
        end
        if (cs_a) miso_a = 1'b0;
        sp_a = sclk_a;
        cp_a = cs_a;
    end

    always @(negedge clk) begin
        if (!cs_b && cp_b) begin bitc_b = 0; cmd_b = '0; addr_b = '0; msr_b = '0; end
        if (sclk_b && !sp_b) tot_rise_b++;
        if (!cs_b && sclk_b && !sp_b) begin
            if (bitc_b < 8) cmd_b = {cmd_b[6:0], mosi_b};
            else if (bitc_b < 32) addr_b = {addr_b[22:0], mosi_b};
            msr_b = {msr_b[62:0], mosi_b};
            bitc_b++;
        end else if (!cs_b && !sclk_b && sp_b) begin
            miso_b = flash_bit(cmd_b, addr_b, bitc_b);
        end
        if (cs_b) miso_b = 1'b0;
        sp_b = sclk_b;
        cp_b = cs_b;
    end

    typedef struct {
        int          tid;
        int          edge0;
        int          done_edge;
        int          deadline;
        int          rise_base;
        int          rises;
        logic [31:0] rx;
        bit          chk_mosi;
        logic [63:0] mosi;
    } txn_t;

    typedef struct {
        int          pid;
        int          at;
        logic        cs;
        logic        busy;
        logic        sclk;
        bit          chk_mosi;
        logic        mosi;
        bit          chk_rx;
        logic [31:0] rx;
    } probe_t;

    txn_t   qa[$], qb[$];
    probe_t qp[$];
    int     checks = 0;
    int     errors = 0;
    int     pidn = 0;

    task automatic chk(input string what, input int id, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (#%0d) at cycle %0d: got %0h want %0h", what, id, cyc, act, exp);
        end
    endtask

    task automatic finish_txn(input txn_t t, input logic [31:0] rx, input int rise_now,
                              input logic [63:0] msr, input logic cs, input logic busy);
        chk("done_edge", t.tid, 64'(cyc - t.edge0), 64'(t.done_edge));
        chk("spiclk_rises", t.tid, 64'(rise_now - t.rise_base), 64'(t.rises));
        chk("rx_data", t.tid, 64'(rx), 64'(t.rx));
        chk("cs_at_done", t.tid, 64'(cs), 64'd1);
        chk("busy_at_done", t.tid, 64'(busy), 64'd0);
        if (t.chk_mosi) chk("mosi_stream", t.tid, msr, t.mosi);
    endtask

    always @(negedge clk) begin : monitor
        probe_t p;
        txn_t   t;
        while (qp.size() > 0 && qp[0].at <= cyc) begin
            p = qp.pop_front();
            if (p.at < cyc) begin
                checks++;
                errors++;
                $display("FAIL probe (#%0d) missed: got cycle %0d want %0d", p.pid, cyc, p.at);
            end else begin
                chk("probe_cs", p.pid, 64'(cs_a), 64'(p.cs));
                chk("probe_busy", p.pid, 64'(busy_a), 64'(p.busy));
                chk("probe_spiclk", p.pid, 64'(sclk_a), 64'(p.sclk));
                if (p.chk_mosi) chk("probe_mosi", p.pid, 64'(mosi_a), 64'(p.mosi));
                if (p.chk_rx) chk("probe_rx", p.pid, 64'(rx_a), 64'(p.rx));
            end
        end
        if (done_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_a_unexpected at cycle %0d: got 1 want 0", cyc);
            end else begin
                t = qa.pop_front();
                finish_txn(t, rx_a, tot_rise_a, msr_a, cs_a, busy_a);
            end
        end else if (qa.size() > 0 && cyc > qa[0].deadline) begin
            t = qa.pop_front();
            checks++;
            errors++;
            $display("FAIL done_a_timeout (#%0d): got no done by cycle %0d want edge %0d", t.tid, cyc, t.done_edge);
        end
        if (done_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_b_unexpected at cycle %0d: got 1 want 0", cyc);
            end else begin
                t = qb.pop_front();
                finish_txn(t, rx_b, tot_rise_b, msr_b, cs_b, busy_b);
            end
        end else if (qb.size() > 0 && cyc > qb[0].deadline) begin
            t = qb.pop_front();
            checks++;
            errors++;
            $display("FAIL done_b_timeout (#%0d): got no done by cycle %0d want edge %0d", t.tid, cyc, t.done_edge);
        end
    end

    task automatic probe(input int at, input logic cs, input logic busy, input logic sclk,
                         input bit cm, input logic m, input bit cr, input logic [31:0] rx);
        probe_t p;
        p.pid = pidn; p.at = at; p.cs = cs; p.busy = busy; p.sclk = sclk;
        p.chk_mosi = cm; p.mosi = m; p.chk_rx = cr; p.rx = rx;
        qp.push_back(p);
        pidn++;
    endtask

    // Called at a negedge; start is sampled on the following posedge (edge 0).
    task automatic issue(input bit on_b, input int tid, input logic [31:0] txd, input int txl,
                         input int rxl, input int done_edge, input int rises, input logic [31:0] rx,
                         input bit chk_mosi, input logic [63:0] mosi, input bit expect_done);
        txn_t t;
        if (on_b) begin
            txd_b = txd; txl_b = 3'(txl); rxl_b = 3'(rxl); start_b = 1'b1;
        end else begin
            txd_a = txd; txl_a = 3'(txl); rxl_a = 3'(rxl); start_a = 1'b1;
        end
        t.tid = tid; t.edge0 = cyc + 1; t.done_edge = done_edge;
        t.deadline = cyc + done_edge + 50;
        t.rise_base = on_b ? tot_rise_b : tot_rise_a;
        t.rises = rises; t.rx = rx; t.chk_mosi = chk_mosi; t.mosi = mosi;
        if (expect_done) begin
            if (on_b) qb.push_back(t); else qa.push_back(t);
        end
        @(negedge clk);
        if (on_b) start_b = 1'b0; else start_a = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || qp.size() > 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            $display("FAIL drain: scoreboard still pending after %0d cycles", limit);
            $fatal(1, "bench stalled");
        end
        @(negedge clk);
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int base;
        int n;
        reset_n = 1'b0;
        start_a = 1'b0; txl_a = '0; rxl_a = '0; txd_a = '0;
        start_b = 1'b0; txl_b = '0; rxl_b = '0; txd_b = '0;
        probe(3, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1, 32'h0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // RDID with timing probes around launch, first bits, and completion
        e0 = cyc + 1;
        probe(e0,      1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 32'h0);
        probe(e0 + 1,  1'b0, 1'b1, 1'b0, 1, 1'b1, 1, 32'h0);
        probe(e0 + 2,  1'b0, 1'b1, 1'b1, 1, 1'b1, 0, 32'h0);
        probe(e0 + 3,  1'b0, 1'b1, 1'b0, 1, 1'b0, 0, 32'h0);
        probe(e0 + 65, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 32'h0);
        probe(e0 + 66, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 32'h00202015);
        probe(e0 + 67, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 32'h00202015);
        issue(0, 1, 32'h9F000000, 1, 3, 66, 32, 32'h00202015, 1, 64'h9F000000, 1);
        drain(300);

        // Zero length: no chip select, no clocks, rx_data holds
        e0 = cyc + 1;
        probe(e0,     1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 32'h00202015);
        probe(e0 + 1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 32'h00202015);
        issue(0, 2, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h00202015, 0, 64'h0, 1);
        drain(100);

        // WREN-style command only
        issue(0, 3, 32'h06000000, 1, 0, 18, 8, 32'h0, 1, 64'h06, 1);
        drain(100);

        // RDID with a stray start and changed inputs mid-transfer
        issue(0, 4, 32'h9F000000, 1, 3, 66, 32, 32'h00202015, 1, 64'h9F000000, 1);
        repeat (20) @(negedge clk);
        txd_a = 32'h06000000; txl_a = 3'd1; rxl_a = 3'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        drain(300);

        // Back-to-back RDID after done
        issue(0, 5, 32'h9F000000, 1, 3, 66, 32, 32'h00202015, 1, 64'h9F000000, 1);
        drain(300);

        // Reset after 10 SPICLK rising edges; no done may follow
        base = tot_rise_a;
        issue(0, 6, 32'h9F000000, 1, 3, 66, 32, 32'h00202015, 1, 64'h9F000000, 0);
        n = 0;
        while (tot_rise_a - base < 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            $display("FAIL reset_mid: got %0d rises want 10", tot_rise_a - base);
            $fatal(1, "bench stalled");
        end
        reset_n = 1'b0;
        probe(cyc + 1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        drain(100);

        // RDID after reset
        issue(0, 7, 32'h9F000000, 1, 3, 66, 32, 32'h00202015, 1, 64'h9F000000, 1);
        drain(300);

        // CLK_DIV = 3 READ at address 0, two data bytes
        issue(1, 8, 32'h03000000, 4, 2, 292, 48, 32'h00005A5B, 1, 64'h030000000000, 1);
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
